// File: rtl/cbus_arbiter.sv
// Two-master arbiter: core ibus/dbus onto the single-beat memory bus (cbus).
// dbus wins ties; a consecutive-dbus-grant counter guarantees ibus progress.
//
// state  | meaning
// IDLE   | no transaction; sample ireq/dreq and grant one
// BUSY_I | latched ibus fetch on cbus, waiting for cresp_ready
// BUSY_D | latched dbus access on cbus, waiting for cresp_ready
module cbus_arbiter #(
    parameter int MAX_CONSEC_D = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        creq_valid,
    output logic        creq_is_write,
    output logic [2:0]  creq_size,
    output logic [63:0] creq_addr,
    output logic [7:0]  creq_strobe,
    output logic [63:0] creq_data,
    input  logic        cresp_ready,
    input  logic [63:0] cresp_data
);

    localparam int CW = (MAX_CONSEC_D < 1) ? 1 : $clog2(MAX_CONSEC_D + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_CONSEC_D);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] consec_d, consec_nxt;
    logic          grant_d, grant_i, done;

    always_comb begin
        state_nxt  = state;
        consec_nxt = consec_d;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (dreq_valid && (!ireq_valid || MAX_CONSEC_D == 0 || consec_d < MAX_C))
                    grant_d = 1'b1;
                else if (ireq_valid)
                    grant_i = 1'b1;
                if (grant_d)
                    state_nxt = BUSY_D;
                else if (grant_i)
                    state_nxt = BUSY_I;
                // The counter only tracks dbus wins while ibus is actually waiting.
                if (!ireq_valid || grant_i)
                    consec_nxt = '0;
                else if (grant_d && consec_d != MAX_C)
                    consec_nxt = consec_d + 1'b1;
            end
            BUSY_I, BUSY_D: begin
                if (cresp_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            consec_d      <= '0;
            creq_valid    <= 1'b0;
            creq_is_write <= 1'b0;
            creq_size     <= 3'd0;
            creq_addr     <= 64'd0;
            creq_strobe   <= 8'd0;
            creq_data     <= 64'd0;
        end else begin
            state    <= state_nxt;
            consec_d <= consec_nxt;
            if (grant_d) begin
                creq_valid    <= 1'b1;
                creq_is_write <= |dreq_strobe;
                creq_size     <= dreq_size;
                creq_addr     <= dreq_addr;
                creq_strobe   <= dreq_strobe;
                creq_data     <= dreq_data;
            end else if (grant_i) begin
                creq_valid    <= 1'b1;
                creq_is_write <= 1'b0;
                creq_size     <= 3'd2;
                creq_addr     <= ireq_addr;
                creq_strobe   <= 8'd0;
                creq_data     <= 64'd0;
            end else if (done) begin
                creq_valid    <= 1'b0;
                creq_is_write <= 1'b0;
                creq_size     <= 3'd0;
                creq_addr     <= 64'd0;
                creq_strobe   <= 8'd0;
                creq_data     <= 64'd0;
            end
        end
    end

    // Responses are combinational so data_ok lands in the same cycle as cresp_ready.
    assign iresp_data_ok = (state == BUSY_I) && cresp_ready;
    assign iresp_addr_ok = iresp_data_ok;
    assign iresp_data    = !iresp_data_ok ? 32'd0 :
                           (creq_addr[2] ? cresp_data[63:32] : cresp_data[31:0]);

    assign dresp_data_ok = (state == BUSY_D) && cresp_ready;
    assign dresp_addr_ok = dresp_data_ok;
    assign dresp_data    = dresp_data_ok ? cresp_data : 64'd0;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_cbus_arbiter;
    localparam int MAXD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ireq_valid, iresp_addr_ok, iresp_data_ok;
    logic [63:0] ireq_addr;
    logic [31:0] iresp_data;
    logic        dreq_valid, dresp_addr_ok, dresp_data_ok;
    logic [63:0] dreq_addr, dreq_data, dresp_data;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        creq_valid, creq_is_write;
    logic [2:0]  creq_size;
    logic [63:0] creq_addr, creq_data;
    logic [7:0]  creq_strobe;
    logic        cresp_ready;
    logic [63:0] cresp_data;

    cbus_arbiter #(.MAX_CONSEC_D(MAXD)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
        .creq_addr(creq_addr), .creq_strobe(creq_strobe), .creq_data(creq_data),
        .cresp_ready(cresp_ready), .cresp_data(cresp_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: who owns the bus (0 none, 1 ibus, 2 dbus), the accepted request,
    // and how many dbus grants ibus has watched go by.
    int          m_owner = 0;
    int          m_dwins = 0;
    logic [63:0] m_addr, m_data;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;
    int          i_ok_cnt = 0;
    int          d_ok_cnt = 0;
    logic        prev_cv = 1'b0;
    byte         glog[$];

    always @(negedge clk) begin
        logic d_wins;
        if (!reset) begin
            m_owner = 0;
            m_dwins = 0;
        end
        chk("creq_valid", creq_valid, m_owner != 0);
        if (m_owner != 0) begin
            chk("creq_addr", creq_addr, m_addr);
            chk("creq_size", creq_size, m_size);
            chk("creq_strobe", creq_strobe, m_strobe);
            chk("creq_data", creq_data, m_data);
            chk("creq_is_write", creq_is_write, m_strobe != 8'd0);
        end
        chk("iresp_data_ok", iresp_data_ok, m_owner == 1 && cresp_ready);
        chk("iresp_addr_ok", iresp_addr_ok, m_owner == 1 && cresp_ready);
        chk("dresp_data_ok", dresp_data_ok, m_owner == 2 && cresp_ready);
        chk("dresp_addr_ok", dresp_addr_ok, m_owner == 2 && cresp_ready);
        if (m_owner == 1 && cresp_ready)
            chk("iresp_data", iresp_data, m_addr[2] ? cresp_data[63:32] : cresp_data[31:0]);
        if (m_owner == 2 && cresp_ready)
            chk("dresp_data", dresp_data, cresp_data);

        if (iresp_data_ok) i_ok_cnt++;
        if (dresp_data_ok) d_ok_cnt++;
        if (creq_valid && !prev_cv) glog.push_back(creq_size == 3'd2 ? 8'h49 : 8'h44);
        prev_cv = creq_valid;

        if (reset) begin
            if (m_owner != 0) begin
                if (cresp_ready) m_owner = 0;
            end else begin
                d_wins = dreq_valid && (!ireq_valid || MAXD == 0 || m_dwins < MAXD);
                if (d_wins) begin
                    m_owner = 2; m_addr = dreq_addr; m_size = dreq_size;
                    m_strobe = dreq_strobe; m_data = dreq_data;
                    if (ireq_valid) m_dwins = (m_dwins + 1 > MAXD) ? MAXD : m_dwins + 1;
                    else m_dwins = 0;
                end else if (ireq_valid) begin
                    m_owner = 1; m_addr = ireq_addr; m_size = 3'd2;
                    m_strobe = 8'd0; m_data = 64'd0;
                    m_dwins = 0;
                end else begin
                    m_dwins = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        byte exp_order[6];
        int  i_seen, d_seen;
        exp_order = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h49, 8'h44};
        ireq_valid = 0; ireq_addr = 0;
        dreq_valid = 0; dreq_addr = 0; dreq_size = 0; dreq_strobe = 0; dreq_data = 0;
        cresp_ready = 0; cresp_data = 0;

        // Reset state
        sample();
        chk("rst_creq_valid", creq_valid, 1'b0);
        chk("rst_iresp_ok", iresp_data_ok, 1'b0);
        chk("rst_dresp_ok", dresp_data_ok, 1'b0);
        step(); reset = 1;

        // Ibus read, memory answers on the third cycle
        step(); ireq_valid = 1; ireq_addr = 64'h8000_0004;
        step();
        step();
        sample();
        chk("i_busy_valid", creq_valid, 1'b1);
        chk("i_busy_size", creq_size, 3'd2);
        chk("i_busy_addr", creq_addr, 64'h8000_0004);
        step(); cresp_ready = 1; cresp_data = 64'h1111_2222_3333_4444;
        sample();
        chk("i_read_ok", iresp_data_ok, 1'b1);
        chk("i_read_data", iresp_data, 32'h1111_2222);
        step(); ireq_valid = 0; cresp_ready = 0;
        sample();
        chk("i_read_pulse_end", iresp_data_ok, 1'b0);

        // Spurious cresp_ready while idle
        step(); cresp_ready = 1;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("spur_iok", iresp_data_ok, 1'b0);
            chk("spur_dok", dresp_data_ok, 1'b0);
            chk("spur_valid", creq_valid, 1'b0);
            step();
        end
        cresp_ready = 0;

        // Concurrent requests: dbus first, ibus right after
        step();
        ireq_valid = 1; ireq_addr = 64'h8000_2000;
        dreq_valid = 1; dreq_addr = 64'h8000_1000; dreq_size = 3; dreq_strobe = 0;
        step();
        sample();
        chk("conc_d_addr", creq_addr, 64'h8000_1000);
        chk("conc_d_write", creq_is_write, 1'b0);
        step(); cresp_ready = 1; cresp_data = 64'h0123_4567_89AB_CDEF;
        sample();
        chk("conc_d_ok", dresp_data_ok, 1'b1);
        chk("conc_d_data", dresp_data, 64'h0123_4567_89AB_CDEF);
        chk("conc_i_waits", iresp_data_ok, 1'b0);
        step(); dreq_valid = 0; cresp_ready = 0;
        sample();
        chk("conc_idle_gap", creq_valid, 1'b0);
        step();
        sample();
        chk("conc_i_valid", creq_valid, 1'b1);
        chk("conc_i_addr", creq_addr, 64'h8000_2000);
        step(); cresp_ready = 1;
        sample();
        chk("conc_i_ok", iresp_data_ok, 1'b1);
        step(); ireq_valid = 0; cresp_ready = 0;

        // Write held across five stalled cycles
        step();
        dreq_valid = 1; dreq_addr = 64'h8000_0100; dreq_size = 3'd2;
        dreq_strobe = 8'h0F; dreq_data = 64'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            step();
            sample();
            chk("wr_valid", creq_valid, 1'b1);
            chk("wr_is_write", creq_is_write, 1'b1);
            chk("wr_strobe", creq_strobe, 8'h0F);
            chk("wr_data", creq_data, 64'hDEAD_BEEF);
            chk("wr_size", creq_size, 3'd2);
        end
        step(); cresp_ready = 1;
        sample();
        chk("wr_done", dresp_data_ok, 1'b1);
        step(); dreq_valid = 0; dreq_strobe = 0; cresp_ready = 0;
        step();

        // Fairness with both sides hammering
        step();
        glog.delete();
        ireq_valid = 1; ireq_addr = 64'h8000_3000;
        dreq_valid = 1; dreq_addr = 64'h8000_4000; dreq_size = 3; dreq_strobe = 0;
        cresp_ready = 1;
        for (int k = 0; k < 40 && glog.size() < 6; k++) sample();
        if (glog.size() >= 6) begin
            for (int k = 0; k < 6; k++) chk($sformatf("fair_grant%0d", k), glog[k], exp_order[k]);
        end else begin
            chk("fair_timeout", glog.size(), 6);
        end
        step(); ireq_valid = 0; dreq_valid = 0; cresp_ready = 0;
        step();

        // Reset during a stalled dbus access, then a clean ibus fetch
        step(); dreq_valid = 1; dreq_addr = 64'h8000_5000; dreq_size = 3; dreq_strobe = 0;
        step();
        step(); reset = 0; cresp_ready = 1; dreq_valid = 0;
        #1;
        chk("rst_mid_valid", creq_valid, 1'b0);
        chk("rst_mid_dok", dresp_data_ok, 1'b0);
        step(); reset = 1; ireq_valid = 1; ireq_addr = 64'h8000_600C;
        cresp_data = 64'hAAAA_BBBB_CCCC_DDDD;
        sample();
        chk("post_rst_c0_ok", iresp_data_ok, 1'b0);
        sample();
        chk("post_rst_c1_ok", iresp_data_ok, 1'b1);
        chk("post_rst_data", iresp_data, 32'hAAAA_BBBB);
        step(); ireq_valid = 0; cresp_ready = 0;

        // Randomized traffic
        i_seen = i_ok_cnt; d_seen = d_ok_cnt;
        for (int c = 0; c < 5000; c++) begin
            step();
            if (!reset) reset = 1;
            else if ($urandom_range(0, 699) == 0) reset = 0;
            if (i_ok_cnt != i_seen) begin
                i_seen = i_ok_cnt;
                ireq_valid = $urandom_range(0, 1);
                ireq_addr = {$urandom, $urandom} & ~64'h3;
            end else if (!ireq_valid) begin
                if ($urandom_range(0, 2) == 0) begin
                    ireq_valid = 1;
                    ireq_addr = {$urandom, $urandom} & ~64'h3;
                end
            end else if ($urandom_range(0, 39) == 0) begin
                ireq_valid = 0;
            end
            if (d_ok_cnt != d_seen || (!dreq_valid && $urandom_range(0, 2) == 0)) begin
                d_seen = d_ok_cnt;
                dreq_valid = (d_ok_cnt != d_seen) ? 1'b1 : $urandom_range(0, 1);
                dreq_valid = dreq_valid | ($urandom_range(0, 1) == 1);
                dreq_addr = {$urandom, $urandom};
                dreq_size = 3'($urandom_range(0, 3));
                dreq_strobe = $urandom_range(0, 1) ? 8'($urandom) : 8'd0;
                dreq_data = {$urandom, $urandom};
            end else if (dreq_valid && $urandom_range(0, 39) == 0) begin
                dreq_valid = 0;
            end
            cresp_ready = ($urandom_range(0, 9) < 4);
            cresp_data = {$urandom, $urandom};
        end
        step(); reset = 1; ireq_valid = 0; dreq_valid = 0; cresp_ready = 0;
        sample();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
